// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter and sequencer for the shared processor bus. Register
// sources (AC, general registers, memory data register) raise read requests.
// The block grants one source at a time, registers the granted source's value
// onto the bus, and limits how long a locked source may keep the bus.
//
// Parameters:
//   reg_width - data width of each source and of the bus
//   N_REQ     - number of requesters (index 0 = control unit / AC path)
//   MAX_HOLD  - maximum consecutive granted cycles for a locked requester
//
// Ports:
//   clk          - single clock, all state changes on the rising edge
//   reset        - synchronous, active-low reset
//   req          - per-source read request
//   lock         - per-source request to keep the bus beyond one cycle
//   data_in      - packed source values, source i at [i*reg_width +: reg_width]
//   gnt          - registered one-hot (or zero) grant
//   bus_out      - registered bus value
//   bus_valid    - bus_out carries a transfer completed on the previous edge
//   bus_src      - index of the source that produced the current bus_out
//   hold_timeout - one-cycle pulse when a locked holder is forcibly released
//
// Configuration macro:
//   BUS_PRIORITY_EN - when defined, requester 0 wins every arbitration point
//                     it takes part in, regardless of the round-robin pointer.
//                     It never preempts a holder that is still entitled to
//                     the bus. When undefined, all requesters are equal.
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int reg_width = 12,
    parameter int N_REQ     = 4,
    parameter int MAX_HOLD  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ*reg_width-1:0] data_in,
    output logic [N_REQ-1:0]           gnt,
    output logic [reg_width-1:0]       bus_out,
    output logic                       bus_valid,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] bus_src,
    output logic                       hold_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [reg_width-1:0] bus_out_q, bus_out_d;
    logic                 bus_valid_q, bus_valid_d;
    logic [IDX_W-1:0]     bus_src_q, bus_src_d;
    logic                 hold_timeout_q, hold_timeout_d;

    logic                 owner_req;
    logic                 owner_lock;
    logic                 keep_owner;
    logic [IDX_W-1:0]     next_ptr;
    logic [N_REQ-1:0]     others;
    logic [N_REQ-1:0]     cand;
    logic [IDX_W-1:0]     win;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Pointer value just past idx, wrapping N_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        if (int'(idx) == N_REQ - 1) begin
            r = '0;
        end else begin
            r = idx + 1'b1;
        end
        return r;
    endfunction

    // First set bit of cand scanning upward from ptr with wrap-around.
    // Callers only use the result when cand is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] cand_in,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && cand_in[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration policy applied at every grant decision.
    function automatic logic [IDX_W-1:0] arb_pick(input logic [N_REQ-1:0] cand_in,
                                                  input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
`ifdef BUS_PRIORITY_EN
        if (cand_in[0]) begin
            pick = '0;
        end else begin
            pick = rr_pick(cand_in, ptr);
        end
`else
        pick = rr_pick(cand_in, ptr);
`endif
        return pick;
    endfunction

    // State register: every flop of the block, cleared by the synchronous
    // active-low reset, which also overrides an ongoing locked hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            owner_q        <= '0;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
            bus_out_q      <= '0;
            bus_valid_q    <= 1'b0;
            bus_src_q      <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            bus_out_q      <= bus_out_d;
            bus_valid_q    <= bus_valid_d;
            bus_src_q      <= bus_src_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    // Next-state logic. In GRANT the current owner transfers whenever it
    // still requests; it keeps the bus only while locked and under the hold
    // limit. On release the owner is left out of the re-arbitration unless
    // it is the only requester, so a released source cannot win back-to-back
    // while others wait, and a new grant is loaded on the same edge.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        bus_out_d      = bus_out_q;
        bus_valid_d    = 1'b0;
        bus_src_d      = bus_src_q;
        hold_timeout_d = 1'b0;

        owner_req  = req[owner_q];
        owner_lock = lock[owner_q];
        keep_owner = owner_req && owner_lock && (hold_cnt_q < CNT_W'(MAX_HOLD));
        next_ptr   = inc_wrap(owner_q);
        others     = req & ~one_hot(owner_q);
        cand       = (|others) ? others : req;
        win        = '0;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    win        = arb_pick(req, ptr_q);
                    owner_d    = win;
                    gnt_d      = one_hot(win);
                    hold_cnt_d = CNT_W'(1);
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                if (owner_req) begin
                    bus_out_d   = data_in[int'(owner_q)*reg_width +: reg_width];
                    bus_src_d   = owner_q;
                    bus_valid_d = 1'b1;
                end

                if (keep_owner) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    // Still requesting and locked here means the limit was hit.
                    hold_timeout_d = owner_req && owner_lock;
                    ptr_d          = next_ptr;
                    if (|cand) begin
                        win        = arb_pick(cand, next_ptr);
                        owner_d    = win;
                        gnt_d      = one_hot(win);
                        hold_cnt_d = CNT_W'(1);
                        state_d    = GRANT;
                    end else begin
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt          = gnt_q;
        bus_out      = bus_out_q;
        bus_valid    = bus_valid_q;
        bus_src      = bus_src_q;
        hold_timeout = hold_timeout_q;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 12-bit processor bus. Register sources (AC, general registers, memory data register) assert read requests; the block grants exactly one source at a time. It registers the granted source's value onto the bus and bounds how long a locked source may hold the bus. It sits between the register file outputs and the bus, driven by the control unit.

## Interface
- `reg_width`, default 12: data width of each source and of the bus.
- `N_REQ`, default 4: number of requesters (index 0 = control unit / AC path).
- `MAX_HOLD`, default 8: maximum consecutive granted cycles for a locked requester (≥1).

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `req`, in, N_REQ: per-source read request.
- `lock`, in, N_REQ: per-source request to keep the bus beyond one cycle.
- `data_in`, in, N_REQ*reg_width: packed source values; source i occupies bits [i*reg_width +: reg_width].
- `gnt`, out, N_REQ: one-hot (or zero) registered grant.
- `bus_out`, out, reg_width: registered bus value.
- `bus_valid`, out, 1: `bus_out` carries a transfer completed on the previous edge.
- `bus_src`, out, $clog2(N_REQ): index of the source that produced the current `bus_out`.
- `hold_timeout`, out, 1: one-cycle pulse when a locked holder is forcibly released.

## Operation
- Reset (`reset`=0 at an edge):
  - `gnt`=0, `bus_out`=0, `bus_valid`=0, `bus_src`=0, `hold_timeout`=0.
  - Internal RR pointer=0, hold counter=0, state IDLE.
  - Overrides all other activity, including mid-hold.
- State IDLE (`gnt`=0): at an edge with any `req` bit set, pick the winner. The winner is the first requesting index scanning upward from the pointer, wrapping N_REQ-1→0. Load the one-hot `gnt` and hold counter=1, then go to GRANT. With no `req`, stay in IDLE.
- State GRANT (source s granted), at each edge:
  - If `req[s]`=1: transfer, with `bus_out`<=`data_in[s]`, `bus_src`<=s, `bus_valid`<=1.
  - If `req[s]`=0: no transfer, `bus_valid`<=0, `bus_out` holds.
  - Stay with s only if `req[s]`=1, `lock[s]`=1 and hold counter < MAX_HOLD. In that case, increment the counter.
  - Otherwise release s and set pointer <= (s+1) mod N_REQ. If other requests are pending at that edge, arbitrate with the updated pointer, load the new `gnt` and go to GRANT (no dead cycle). If none are pending, go to IDLE.
  - If the release is caused by the counter reaching MAX_HOLD while `req[s]`&`lock[s]` are still 1, `hold_timeout`<=1 for one cycle.
- `bus_valid` is 0 in any cycle following an edge without a transfer. `bus_out` and `bus_src` then hold their last values.
- Source s is excluded from the re-arbitration at its own release edge, so it cannot win back-to-back when others request. If s is the only requester, it is re-granted.
- `lock` is ignored when `req` is 0. `lock` alone never creates a grant.

## Timing
- Request at edge k (IDLE) → `gnt` visible after edge k.
- Transfer at edge k+1 → `bus_out`/`bus_valid` visible after edge k+1. Request-to-data latency is 2 edges.
- Unlocked source: 1 granted cycle, 1 transfer.
- Locked source: at most MAX_HOLD granted cycles and MAX_HOLD transfers.
- Continuous requests from all sources give one transfer per cycle, with no idle gaps between grants.
- `data_in` is sampled only at transfer edges. It must be stable at the edge only.

## Configuration
- `BUS_PRIORITY_EN` defined: at every arbitration point, requester 0 wins if `req[0]`=1, regardless of the pointer. The pointer still advances past each released source. Requester 0 never preempts an active locked holder; it waits for release.
- Not defined: pure round-robin as above, with all requesters equal.

## Test plan
- Reset: `reset`=0 for 2 cycles with `req`=4'b1111 → all outputs 0, no grant. Release reset → `gnt`=4'b0001 after the first edge.
- Round robin: `req`=4'b1111 held, `lock`=0, `data_in`={12'h444,12'h333,12'h222,12'h111} → `bus_out` sequence 111,222,333,444,111 on consecutive cycles, `bus_valid` continuously 1.
- Lock limit (MAX_HOLD=8): `req`=4'b0110, `lock[1]`=1 held → 8 consecutive transfers from source 1, `hold_timeout` pulse once, then `gnt`=4'b0100.
- Drop while granted: source 2 granted, `req[2]`→0 before the transfer edge → no transfer, `bus_valid`=0, `bus_out` unchanged, grant moves or returns to IDLE.
- Reset mid-hold: source 3 locked at count 4, `reset`=0 → next cycle `gnt`=0, `bus_valid`=0, pointer 0. After release, `req`=4'b1010 → source 1 granted first.
- `BUS_PRIORITY_EN`: pointer at 2, `req`=4'b0101 → source 0 granted. Without the macro → source 2 granted.
